seg7_scan4: RTL



---
 rtl/seg7_scan4_pkg.sv | 14 +
 rtl/seg7_scan4_hex_to_seg7.sv | 11 +
 rtl/seg7_scan4.sv | 86 ++++++++
 3 files changed

// File: rtl/seg7_scan4_pkg.sv
// Shared constants for the seven-segment display blocks.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package seg7_scan4_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Index n gives the segment pattern for hex digit n (entry 0 is rightmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_scan4_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_scan4_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed common-anode display driver with per-frame snapshot,
// anti-ghosting guard time and optional leading-zero blanking.
module seg7_scan4
  import seg7_scan4_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [15:0]      snap;

  logic             wrap_c;
  logic [3:0]       nib_c;
  logic [6:0]       dec_c;
  logic             blank_c;
  logic [6:0]       seg_nxt_c;
  logic             dp_nxt_c;
  logic [3:0]       an_nxt_c;

  hex_to_seg7 u_dec (
    .hex   (nib_c),
    .seg_c (dec_c)
  );

  // Digit i is a leading zero when snap nibbles i..3 are all zero; digit 0 always shows.
  always_comb begin
    wrap_c  = (div == DIV_LAST);
    nib_c   = snap[{idx, 2'b00} +: 4];
    blank_c = 1'b0;
    unique case (idx)
      2'd0: blank_c = 1'b0;
      2'd1: blank_c = (snap[15:4]  == 12'h000);
      2'd2: blank_c = (snap[15:8]  == 8'h00);
      2'd3: blank_c = (snap[15:12] == 4'h0);
      default: blank_c = 1'b0;
    endcase
    blank_c   = blank_c & blank_lz;
    seg_nxt_c = blank_c ? SEG_OFF : dec_c;
    dp_nxt_c  = blank_c | ~dp_mask[idx];
    an_nxt_c  = (div < GUARD_END) ? AN_OFF : ~(4'b0001 << idx);
  end

  // Slot divider, digit index and frame snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div  <= '0;
      idx  <= 2'd0;
      snap <= 16'h0000;
    end else begin
      div <= wrap_c ? '0 : div + 1'b1;
      if (wrap_c) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) snap <= val;
      end
    end
  end

  // Output registers: one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      dp  <= 1'b1;
      an  <= AN_OFF;
    end else begin
      seg <= seg_nxt_c;
      dp  <= dp_nxt_c;
      an  <= an_nxt_c;
    end
  end

endmodule
